// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
// The PARITY state is only reachable when PARITY_EN is defined.
package piso_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } piso_state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Bits needed to hold a bit index of a WIDTH-bit word (0 .. WIDTH-1).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a valid/ready load and a shift_en bit tick.
// Define PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] in,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             done_q, done_d;
`ifdef PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [WIDTH-1:0] shreg_shifted;
    logic             in_head;
    logic             shifted_head;

    // The bit on ser_out is always the head of the shift register in the chosen direction.
    always_comb begin
        if (MSB_FIRST) begin
            shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
            in_head       = in[WIDTH-1];
            shifted_head  = shreg_shifted[WIDTH-1];
        end else begin
            shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
            in_head       = in[0];
            shifted_head  = shreg_shifted[0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (shift_en && (cnt_q == '0)) begin
`ifdef PARITY_EN
                    state_d = StParity;
`else
                    state_d = StIdle;
`endif
                end
            end
            StParity: begin
`ifdef PARITY_EN
                if (shift_en) begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: shift register, bit counter and registered serial outputs.
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        done_d      = 1'b0;
`ifdef PARITY_EN
        parity_d    = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
                if (load_valid) begin
                    shreg_d     = in;
                    cnt_d       = CNT_LAST;
                    ser_out_d   = in_head;
                    ser_valid_d = 1'b1;
`ifdef PARITY_EN
                    parity_d    = ^in;
`endif
                end
            end
            StShift: begin
                if (shift_en) begin
                    if (cnt_q != '0) begin
                        shreg_d   = shreg_shifted;
                        cnt_d     = cnt_q - CW'(1);
                        ser_out_d = shifted_head;
                    end else begin
`ifdef PARITY_EN
                        ser_out_d   = parity_q;
                        ser_valid_d = 1'b1;
`else
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
                        done_d      = 1'b1;
`endif
                    end
                end
            end
            StParity: begin
                if (shift_en) begin
                    ser_out_d   = 1'b0;
                    ser_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
`ifdef PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Outputs
    always_comb begin
        load_ready = (state_q == StIdle);
        busy       = (state_q != StIdle);
        ser_out    = ser_out_q;
        ser_valid  = ser_valid_q;
        done       = done_q;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-of-bits frame model; honours PARITY_EN.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         shift_en = 1'b0;
    logic [W-1:0] din = '0;

    logic load_ready_m, ser_out_m, ser_valid_m, busy_m, done_m;
    logic load_ready_l, ser_out_l, ser_valid_l, busy_l, done_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_m),
        .in(din), .shift_en(shift_en), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
        .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_l),
        .in(din), .shift_en(shift_en), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Frame model: a queue of the bits still to be sent; the head is on the wire.
    bit q_m[$];
    bit q_l[$];
    bit m_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q_m.delete();
            q_l.delete();
            m_done = 1'b0;
        end else if (q_m.size() == 0) begin
            m_done = 1'b0;
            if (load_valid) begin
                for (int i = W - 1; i >= 0; i--) q_m.push_back(din[i]);
                for (int i = 0; i < W; i++) q_l.push_back(din[i]);
                if (PB == 1) begin
                    q_m.push_back(^din);
                    q_l.push_back(^din);
                end
            end
        end else begin
            m_done = 1'b0;
            if (shift_en) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
                if (q_m.size() == 0) m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", ser_valid_m, q_m.size() != 0);
            check("m_out", ser_out_m, (q_m.size() != 0) ? q_m[0] : 1'b0);
            check("m_busy", busy_m, q_m.size() != 0);
            check("m_ready", load_ready_m, q_m.size() == 0);
            check("m_done", done_m, m_done);
            check("l_valid", ser_valid_l, q_l.size() != 0);
            check("l_out", ser_out_l, (q_l.size() != 0) ? q_l[0] : 1'b0);
            check("l_done", done_l, m_done);
        end
    end

    // Log of bits actually consumed from the wire (valid and shift_en in the same cycle).
    logic [63:0] acc_m = '0;
    logic [63:0] acc_l = '0;
    int rec_n = 0;
    int vcount = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (ser_valid_m) vcount++;
            if (ser_valid_m && shift_en) begin
                acc_m = {acc_m[62:0], ser_out_m};
                acc_l = {acc_l[62:0], ser_out_l};
                rec_n++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] w);
        load_valid = 1'b1;
        din = w;
        tick();
        load_valid = 1'b0;
        din = W'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_m && cyc < 40) begin
            tick();
            cyc++;
        end
        if (cyc >= 40) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_bits(input string name, input int start, input logic [31:0] exp_m,
                              input logic [31:0] exp_l);
        int n;
        logic [31:0] mask;
        n = rec_n - start;
        mask = (32'd1 << n) - 32'd1;
        check({name, "_nbits"}, n, W + PB);
        check({name, "_msb"}, acc_m[31:0] & mask, exp_m);
        check({name, "_lsb"}, acc_l[31:0] & mask, exp_l);
    endtask

    initial begin
        int c, s, v0;
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c, s, v0;
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        check("rst_ready", load_ready_m, 1);
        check("rst_valid", ser_valid_m, 0);
        check("rst_out", ser_out_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_done", done_m, 0);

        // 1/2: 1011, continuous shift_en, both bit orders
        shift_en = 1'b1;
        s = rec_n;
        load(4'b1011);
        check("t1_first_m", {ser_valid_m, ser_out_m}, 2'b11);
        check("t1_first_l", {ser_valid_l, ser_out_l}, 2'b11);
        wait_done(c);
        check("t1_done_cycle", 1 + c, W + 1 + PB);
        check("t1_ready_back", load_ready_m, 1);
        check("t1_done_l", done_l, 1);
        check_bits("t1", s, (PB == 1) ? 32'b10111 : 32'b1011, (PB == 1) ? 32'b11011 : 32'b1101);

        // 3: shift_en pattern 1,0,0,1 on 0110, loaded back-to-back in the done cycle
        shift_en = 1'b0;
        s = rec_n;
        v0 = vcount;
        load(4'b0110);
        for (int k = 1; k < 40 && !done_m; k++) begin
            shift_en = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
            tick();
        end
        check("t3_valid_cycles", vcount - v0, 8 + PB);
        check_bits("t3", s, (PB == 1) ? 32'b01100 : 32'b0110, (PB == 1) ? 32'b01100 : 32'b0110);

        // 4: load attempt while busy is ignored, then taken in the done cycle
        shift_en = 1'b1;
        tick();
        s = rec_n;
        load(4'b0001);
        tick();
        load_valid = 1'b1;
        din = 4'b1111;
        check("t4_not_ready", load_ready_m, 0);
        wait_done(c);
        check("t4_done_cycle", 2 + c, W + 1 + PB);
        check_bits("t4a", s, (PB == 1) ? 32'b00011 : 32'b0001, (PB == 1) ? 32'b10001 : 32'b1000);
        s = rec_n;
        tick();
        load_valid = 1'b0;
        din = '0;
        check("t4_b2b_start", {ser_valid_m, ser_out_m}, 2'b11);
        wait_done(c);
        check_bits("t4b", s, (PB == 1) ? 32'b11110 : 32'b1111, (PB == 1) ? 32'b11110 : 32'b1111);

        // 5: reset during bit 3 aborts the frame
        tick();
        load(4'b1011);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_valid", ser_valid_m, 0);
        check("t5_busy", busy_m, 0);
        check("t5_done", done_m, 0);
        check("t5_ready", load_ready_m, 1);
        check("t5_valid_l", ser_valid_l, 0);
        s = rec_n;
        load(4'b1001);
        wait_done(c);
        check("t5_done_cycle", 1 + c, W + 1 + PB);
        check_bits("t5", s, (PB == 1) ? 32'b10010 : 32'b1001, (PB == 1) ? 32'b10010 : 32'b1001);

`ifdef PARITY_EN
        // 6: parity bit on the wire for 1011 (odd weight) and 1001 (even weight)
        tick();
        load(4'b1011);
        repeat (4) tick();
        check("t6_par1", {ser_valid_m, ser_out_m}, 2'b11);
        wait_done(c);
        tick();
        load(4'b1001);
        repeat (4) tick();
        check("t6_par0", {ser_valid_m, ser_out_m}, 2'b10);
        wait_done(c);
        check("t6_done_cycle", 5 + c, 6);
`endif

        shift_en = 1'b0;
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
